drbg_key_slicer: RTL and testbench
==================================

// Module: drbg_key_slicer
// PURPOSE
//  Consumer stage behind master_hash_slave_hash_drbg. Fetches 256-bit random words over the DRBG
//  next_bits/next_bits_ready level handshake and holds up to two words in a ping-pong buffer.
//  Each word is cut into KEY_WIDTH-bit per-line scramble keys for the video line scrambler
//  (valid/ready). Prefetch hides DRBG hash latency from line-rate key demand.
// PARAMETERS
//  WORD_WIDTH  256  DRBG random_bits width
//  KEY_WIDTH   16   key slice width; WORD_WIDTH % KEY_WIDTH == 0 (elaboration error otherwise)
//  CNT_WIDTH   32   width of words_consumed counter
// PORTS
//  clk                  in   1            system clock, all logic on rising edge
//  reset_n              in   1            asynchronous active-low reset
//  enable               in   1            allow new DRBG requests
//  flush                in   1            sync clear of buffer/pointer/underrun (frame resync, reseed)
//  drbg_init_ready      in   1            DRBG instantiated; requests only while high
//  drbg_next_bits       out  1            request level to DRBG
//  drbg_next_bits_ready in   1            DRBG word available
//  drbg_random_bits     in   WORD_WIDTH   DRBG word, valid while next_bits_ready high
//  key_valid            out  1            key holds a slice
//  key_ready            in   1            scrambler takes key this cycle
//  key                  out  KEY_WIDTH    current slice
//  underrun             out  1            sticky: key_ready seen with key_valid low while enable high
//  words_consumed       out  CNT_WIDTH    fully consumed words, wraps modulo 2^CNT_WIDTH
// BEHAVIOUR
//  Reset: drbg_next_bits=0, key_valid=0, key=0, underrun=0, words_consumed=0, count=0, ptr=0, FSM=IDLE.
//  Buffer: slots[0:1], rd slot index, count 0..2, slice ptr 0..N-1 (N=WORD_WIDTH/KEY_WIDTH).
//  key = slots[rd][ptr*KEY_WIDTH +: KEY_WIDTH] (LSB slice first); key_valid = (count!=0), combinational.
//  Request FSM (one request in flight max):
//   IDLE:    enable & drbg_init_ready & !flush & count<2 -> REQ, drbg_next_bits<=1.
//   REQ:     drbg_next_bits_ready==1 -> capture drbg_random_bits into wr slot, drbg_next_bits<=0,
//            -> RELEASE. Capture is suppressed (discard) if flush seen since entering REQ, or flush
//            asserted this cycle. Drop of enable/init_ready in REQ does not abort; keep waiting.
//   RELEASE: wait drbg_next_bits_ready==0 -> IDLE (earliest re-request the cycle after).
//  Capture->key_valid latency: 1 cycle (count updates at capture edge).
//  Consume: key_valid & key_ready -> ptr++; at ptr==N-1 ptr<=0, rd toggles, count--, words_consumed++.
//  Simultaneous capture and word pop: count unchanged, both take effect.
//  count==2 with consume in progress: no request until a pop makes count<2.
//  Underrun: key_ready & !key_valid & enable -> underrun<=1, held until flush or reset.
//  flush (priority over consume and capture): count<=0, ptr<=0, rd<=0, underrun<=0; words_consumed
//   kept; FSM stays in REQ/RELEASE if mid-handshake so DRBG handshake closes cleanly.
//  Async reset mid-handshake: drbg_next_bits drops immediately; DRBG side is reset from same reset_n.
// STRUCTURE
//  scrambler_pkg: KEY_WIDTH/WORD_WIDTH defaults, request FSM state localparams (IDLE/REQ/RELEASE).
//  One sub-module natural: drbg_req_fsm (handshake FSM, outputs capture strobe); buffer/slicer inline.
// TESTING
//  Reused DRBG stub with 3-cycle latency returning words 0x..0001,0x..0002,... (LSB word index):
//  1 Reset, enable=1, init_ready=1, key_ready=0 -> two requests, count=2, then drbg_next_bits stays 0;
//    key=16'h0001 valid.
//  2 key_ready=1 continuous -> keys 0x0001,0,0,...(16 slices) then 0x0002 slice; words_consumed=1
//    after 16th accept; refill request issued once count<2; no gap in key_valid.
//  3 init_ready=0 from reset -> drbg_next_bits never asserts; key_ready pulse -> underrun=1; flush -> 0.
//  4 flush while in REQ, stub answers next cycle -> word discarded, count stays 0, FSM returns IDLE,
//    new request follows; next key equals the following stub word.
//  5 Pop of last slice same cycle as capture with count=1 -> count stays 1, key = new word slice 0.
//  6 reset_n low mid-REQ -> all outputs reset values asynchronously; after release behaves as test 1.

Source files
------------

// File: rtl/scrambler_pkg.sv
// Shared defaults and request-FSM state encoding for the DRBG key slicer.
package scrambler_pkg;

    localparam int WORD_WIDTH_DEF = 256;
    localparam int KEY_WIDTH_DEF  = 16;
    localparam int CNT_WIDTH_DEF  = 32;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_RELEASE = 2'd2
    } req_state_e;

endpackage : scrambler_pkg

// File: rtl/drbg_req_fsm.sv
// DRBG next_bits/next_bits_ready level handshake with at most one request in flight.
// capture_o strobes for the one cycle a returned word must be written into the buffer.
module drbg_req_fsm
    import scrambler_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic enable_i,
    input  logic flush_i,
    input  logic init_ready_i,
    input  logic buf_full_i,
    input  logic next_bits_ready_i,
    output logic next_bits_o,
    output logic capture_o
);

    req_state_e state_q, state_d;
    logic       req_q, req_d;
    logic       flushed_q, flushed_d;

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            req_q     <= 1'b0;
            flushed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            flushed_q <= flushed_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        flushed_d = flushed_q;
        capture_o = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (enable_i && init_ready_i && !flush_i && !buf_full_i) begin
                    state_d   = S_REQ;
                    req_d     = 1'b1;
                    flushed_d = 1'b0;
                end
            end
            S_REQ: begin
                // A word requested before a flush belongs to the old stream and is dropped.
                if (next_bits_ready_i) begin
                    capture_o = !(flushed_q || flush_i);
                    req_d     = 1'b0;
                    state_d   = S_RELEASE;
                end else if (flush_i) begin
                    flushed_d = 1'b1;
                end
            end
            S_RELEASE: begin
                if (!next_bits_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    assign next_bits_o = req_q;

endmodule : drbg_req_fsm

// File: rtl/drbg_key_slicer.sv
// Two-word ping-pong buffer fed by the DRBG, sliced LSB-first into per-line scramble keys.
module drbg_key_slicer
    import scrambler_pkg::*;
#(
    parameter int WORD_WIDTH = WORD_WIDTH_DEF,
    parameter int KEY_WIDTH  = KEY_WIDTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  flush,
    input  logic                  drbg_init_ready,
    output logic                  drbg_next_bits,
    input  logic                  drbg_next_bits_ready,
    input  logic [WORD_WIDTH-1:0] drbg_random_bits,
    output logic                  key_valid,
    input  logic                  key_ready,
    output logic [KEY_WIDTH-1:0]  key,
    output logic                  underrun,
    output logic [CNT_WIDTH-1:0]  words_consumed
);

    localparam int N     = WORD_WIDTH / KEY_WIDTH;
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    if (WORD_WIDTH % KEY_WIDTH != 0) begin : g_width_check
        $error("WORD_WIDTH must be an integer multiple of KEY_WIDTH");
    end

    logic [WORD_WIDTH-1:0] slot_q [2];
    logic                  rd_q, rd_d;
    logic [1:0]            count_q, count_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic                  underrun_q, underrun_d;
    logic [CNT_WIDTH-1:0]  words_q, words_d;
    logic                  capture;
    logic                  accept;
    logic                  pop;
    logic                  wr_idx;

    drbg_req_fsm u_req_fsm (
        .clk               (clk),
        .reset_n           (reset_n),
        .enable_i          (enable),
        .flush_i           (flush),
        .init_ready_i      (drbg_init_ready),
        .buf_full_i        (count_q == 2'd2),
        .next_bits_ready_i (drbg_next_bits_ready),
        .next_bits_o       (drbg_next_bits),
        .capture_o         (capture)
    );

    assign key_valid = (count_q != 2'd0);
    assign accept    = key_valid && key_ready;
    assign pop       = accept && (ptr_q == PTR_W'(N - 1));
    // With one word held the free slot is the other one; a same-cycle pop makes it the new rd.
    assign wr_idx    = rd_q ^ (count_q == 2'd1);

    // NOTE: the word storage has no reset; key is gated by key_valid so stale data never shows.
    always_ff @(posedge clk) begin
        if (capture) begin
            slot_q[wr_idx] <= drbg_random_bits;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_q       <= 1'b0;
            count_q    <= 2'd0;
            ptr_q      <= '0;
            underrun_q <= 1'b0;
            words_q    <= '0;
        end else begin
            rd_q       <= rd_d;
            count_q    <= count_d;
            ptr_q      <= ptr_d;
            underrun_q <= underrun_d;
            words_q    <= words_d;
        end
    end

    always_comb begin
        rd_d       = rd_q;
        count_d    = count_q;
        ptr_d      = ptr_q;
        underrun_d = underrun_q;
        words_d    = words_q;
        if (flush) begin
            rd_d       = 1'b0;
            count_d    = 2'd0;
            ptr_d      = '0;
            underrun_d = 1'b0;
        end else begin
            if (accept) begin
                ptr_d = pop ? '0 : ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_d    = ~rd_q;
                words_d = words_q + CNT_WIDTH'(1);
            end
            count_d = count_q + 2'(capture) - 2'(pop);
            if (key_ready && !key_valid && enable) begin
                underrun_d = 1'b1;
            end
        end
    end

    assign key            = key_valid ? slot_q[rd_q][ptr_q*KEY_WIDTH +: KEY_WIDTH] : '0;
    assign underrun       = underrun_q;
    assign words_consumed = words_q;

endmodule : drbg_key_slicer

// File: tb/tb_drbg_key_slicer.sv
// Self-checking bench: 3-cycle DRBG stub feeding a key scoreboard, plus directed corner cases.
module tb_drbg_key_slicer;

    localparam int WW = 256;
    localparam int KW = 16;
    localparam int CW = 32;
    localparam int NS = WW / KW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b1;
    logic          flush = 1'b0;
    logic          drbg_init_ready = 1'b1;
    logic          drbg_next_bits;
    logic          drbg_next_bits_ready;
    logic [WW-1:0] drbg_random_bits;
    logic          key_valid;
    logic          key_ready = 1'b0;
    logic [KW-1:0] key;
    logic          underrun;
    logic [CW-1:0] words_consumed;

    always #5 clk = ~clk;

    drbg_key_slicer #(.WORD_WIDTH(WW), .KEY_WIDTH(KW), .CNT_WIDTH(CW)) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .enable               (enable),
        .flush                (flush),
        .drbg_init_ready      (drbg_init_ready),
        .drbg_next_bits       (drbg_next_bits),
        .drbg_next_bits_ready (drbg_next_bits_ready),
        .drbg_random_bits     (drbg_random_bits),
        .key_valid            (key_valid),
        .key_ready            (key_ready),
        .key                  (key),
        .underrun             (underrun),
        .words_consumed       (words_consumed)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // DRBG stub and scoreboard share one process, evaluated on the falling edge.
    logic          stub_rdy = 1'b0;
    logic [WW-1:0] stub_bits = '0;
    int            stub_lat = 0;
    int            stub_idx = 0;
    int            req_rises = 0;
    int            slice_cnt = 0;
    logic [CW-1:0] exp_words = '0;
    logic          prev_req = 1'b0;
    logic          discard_pending = 1'b0;
    logic [KW-1:0] exp_q[$];

    assign drbg_next_bits_ready = stub_rdy;
    assign drbg_random_bits     = stub_bits;

    always @(negedge clk) begin
        if (!reset_n) begin
            stub_rdy        = 1'b0;
            stub_lat        = 0;
            stub_idx        = 0;
            req_rises       = 0;
            slice_cnt       = 0;
            exp_words       = '0;
            prev_req        = 1'b0;
            discard_pending = 1'b0;
            exp_q.delete();
        end else begin
            if (drbg_next_bits && !prev_req) req_rises++;
            prev_req = drbg_next_bits;
            if (flush) begin
                exp_q.delete();
                slice_cnt = 0;
                if (drbg_next_bits && !stub_rdy) discard_pending = 1'b1;
            end else if (key_valid && key_ready) begin
                if (exp_q.size() == 0) check("unexpected_key_valid", 64'(key_valid), 64'(0));
                else check("key", 64'(key), 64'(exp_q.pop_front()));
                if (slice_cnt == NS - 1) begin
                    slice_cnt = 0;
                    exp_words = exp_words + 1;
                end else begin
                    slice_cnt++;
                end
            end
            if (stub_rdy) begin
                if (!drbg_next_bits) stub_rdy = 1'b0;
            end else if (drbg_next_bits) begin
                if (stub_lat == 2) begin
                    stub_lat  = 0;
                    stub_idx++;
                    stub_bits = WW'(stub_idx);
                    stub_rdy  = 1'b1;
                    if (discard_pending) discard_pending = 1'b0;
                    else for (int j = 0; j < NS; j++) exp_q.push_back(stub_bits[j*KW +: KW]);
                end else begin
                    stub_lat++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
    endtask

    task automatic accept_n(input int n);
        key_ready = 1'b1;
        repeat (n) step();
        key_ready = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 10 && !drbg_next_bits; i++) step();
        check(tag, 64'(drbg_next_bits), 64'(1));
    endtask

    int r0;
    logic sync_ok;

    initial begin
        // Reset values
        repeat (2) step();
        check("rst_next_bits", 64'(drbg_next_bits), 64'(0));
        check("rst_key_valid", 64'(key_valid), 64'(0));
        check("rst_key", 64'(key), 64'(0));
        check("rst_underrun", 64'(underrun), 64'(0));
        check("rst_words", 64'(words_consumed), 64'(0));
        reset_n = 1'b1;

        // 1: prefetch fills both slots then stops requesting
        repeat (30) step();
        check("t1_req_count", 64'(req_rises), 64'(2));
        check("t1_next_bits_idle", 64'(drbg_next_bits), 64'(0));
        check("t1_key_valid", 64'(key_valid), 64'(1));
        check("t1_key", 64'(key), 64'(16'h0001));

        // 2: continuous consumption with refill and no gap
        accept_n(16);
        check("t2_words_after_16", 64'(words_consumed), 64'(exp_words));
        accept_n(24);
        check("t2_no_gap", 64'(underrun), 64'(0));
        check("t2_words", 64'(words_consumed), 64'(exp_words));
        check("t2_refills", 64'(req_rises), 64'(2 + int'(exp_words)));

        // 3: DRBG not instantiated, underrun set and cleared
        drbg_init_ready = 1'b0;
        apply_reset();
        repeat (20) step();
        check("t3_no_req", 64'(req_rises), 64'(0));
        check("t3_key_valid", 64'(key_valid), 64'(0));
        key_ready = 1'b1;
        step();
        key_ready = 1'b0;
        check("t3_underrun_set", 64'(underrun), 64'(1));
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("t3_underrun_flushed", 64'(underrun), 64'(0));
        enable = 1'b0;
        key_ready = 1'b1;
        step();
        key_ready = 1'b0;
        enable = 1'b1;
        check("t3_underrun_needs_enable", 64'(underrun), 64'(0));

        // 4: flush while a request is in flight discards that word
        drbg_init_ready = 1'b1;
        apply_reset();
        wait_req("t4_req");
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("t4_empty_after_flush", 64'(key_valid), 64'(0));
        repeat (30) step();
        check("t4_key_valid", 64'(key_valid), 64'(1));
        check("t4_key_next_word", 64'(key), 64'(16'h0002));
        check("t4_words_kept", 64'(words_consumed), 64'(0));

        // 5: last-slice pop coincides with capture while one word is held
        apply_reset();
        repeat (30) step();
        enable = 1'b0;
        accept_n(16);
        accept_n(15);
        enable = 1'b1;
        sync_ok = 1'b0;
        for (int i = 0; i < 20 && !sync_ok; i++) begin
            step();
            sync_ok = drbg_next_bits && !stub_rdy && (stub_lat == 2);
        end
        check("t5_sync", 64'(sync_ok), 64'(1));
        accept_n(1);
        check("t5_key_valid", 64'(key_valid), 64'(1));
        check("t5_key_new_word", 64'(key), 64'(16'h0003));
        check("t5_words", 64'(words_consumed), 64'(exp_words));
        r0 = req_rises;
        repeat (8) step();
        check("t5_count_one_refill", 64'(req_rises), 64'(r0 + 1));

        // 6: asynchronous reset in the middle of a request
        apply_reset();
        wait_req("t6_req");
        #1 reset_n = 1'b0;
        #1;
        check("t6_next_bits_async", 64'(drbg_next_bits), 64'(0));
        check("t6_key_valid_async", 64'(key_valid), 64'(0));
        check("t6_key_async", 64'(key), 64'(0));
        check("t6_words_async", 64'(words_consumed), 64'(0));
        repeat (2) step();
        reset_n = 1'b1;
        repeat (30) step();
        check("t6_req_count", 64'(req_rises), 64'(2));
        check("t6_next_bits_idle", 64'(drbg_next_bits), 64'(0));
        check("t6_key", 64'(key), 64'(16'h0001));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_drbg_key_slicer
